clk_alarm_responder: RTL

- Consumer end of the clock-glitch detector's alarm interface: receives single-cycle alarm pulses and escalates the system response.
- Escalation order: interrupt, then core halt, then core reset request, then permanent lockout.
- Sits between the detector's alarm output and the cv32e40p irq, fetch-enable and reset-request inputs.
- Keeps alarm statistics and an exposed state for software and debug.

---
 rtl/clk_alarm_responder_if.sv | 25 ++
 rtl/clk_alarm_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/clk_alarm_responder_if.sv
// Alarm responder bundle: detector/software controls in, escalation outputs back.
// master = alarm source / software side, slave = the responder itself.
interface clk_alarm_responder_if #(
  parameter int CNT_W = 8
);
  logic             alarm_i;
  logic             irq_ack_i;
  logic             sw_clear_i;
  logic             irq_o;
  logic             halt_o;
  logic             reset_req_o;
  logic             lockout_o;
  logic [CNT_W-1:0] alarm_cnt_o;
  logic [2:0]       state_o;

  modport master (
    output alarm_i, irq_ack_i, sw_clear_i,
    input  irq_o, halt_o, reset_req_o, lockout_o, alarm_cnt_o, state_o
  );

  modport slave (
    input  alarm_i, irq_ack_i, sw_clear_i,
    output irq_o, halt_o, reset_req_o, lockout_o, alarm_cnt_o, state_o
  );
endinterface

// File: rtl/clk_alarm_responder.sv
// Escalating response to clock-glitch alarms: irq -> halt -> core reset -> lockout.
// Alarm rate is judged over a sliding-start window that opens on the first alarm.
module clk_alarm_responder #(
  parameter int ALARM_THRESHOLD = 3,
  parameter int WINDOW_CYCLES   = 1024,
  parameter int HALT_CYCLES     = 16,
  parameter int MAX_RESETS      = 2,
  parameter int CNT_W           = 8
) (
  input logic                  clk,
  input logic                  rst,
  clk_alarm_responder_if.slave bus
);
  localparam int WT_W = $clog2(WINDOW_CYCLES);
  localparam int HT_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

  localparam logic [WT_W-1:0]  WIN_LAST  = WT_W'(WINDOW_CYCLES - 1);
  localparam logic [WT_W-1:0]  WT_ONE    = WT_W'(1);
  localparam logic [HT_W-1:0]  HALT_LAST = HT_W'(HALT_CYCLES - 1);
  localparam logic [HT_W-1:0]  HT_ONE    = HT_W'(1);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(ALARM_THRESHOLD);
  localparam logic [CNT_W-1:0] THR_M1    = CNT_W'(ALARM_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(MAX_RESETS - 1);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALERT     = 3'd1,
    HALT      = 3'd2,
    RESET_REQ = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [WT_W-1:0]  win_timer_q, win_timer_d;
  logic [HT_W-1:0]  halt_timer_q, halt_timer_d;
  logic             irq_q, irq_d, halt_q, halt_d, rr_q, rr_d, lock_q, lock_d;

  logic             sw_ok, win_expire, win_hit;
  logic [CNT_W-1:0] cnt_base, win_base_cnt;
  logic [WT_W-1:0]  win_base_tmr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      alarm_cnt_q  <= '0;
      win_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      win_timer_q  <= '0;
      halt_timer_q <= '0;
      irq_q        <= 1'b0;
      halt_q       <= 1'b0;
      rr_q         <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_cnt_q  <= alarm_cnt_d;
      win_cnt_q    <= win_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      win_timer_q  <= win_timer_d;
      halt_timer_q <= halt_timer_d;
      irq_q        <= irq_d;
      halt_q       <= halt_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    halt_timer_d = '0;
    win_cnt_d    = '0;
    win_timer_d  = '0;

    // Software clear only lands in the non-escalated states; it is applied
    // before any same-cycle alarm is counted.
    sw_ok    = bus.sw_clear_i && (state_q == IDLE || state_q == ALERT);
    cnt_base = sw_ok ? '0 : alarm_cnt_q;
    alarm_cnt_d = cnt_base;
    if (bus.alarm_i && state_q != LOCKOUT && cnt_base != '1)
      alarm_cnt_d = cnt_base + C_ONE;

    // An alarm on the expiry cycle sees an empty window and starts a fresh one.
    win_expire   = (win_cnt_q != '0) && (win_timer_q == WIN_LAST);
    win_base_cnt = (sw_ok || win_expire) ? '0 : win_cnt_q;
    win_base_tmr = (sw_ok || win_expire || win_cnt_q == '0) ? '0 : win_timer_q + WT_ONE;
    win_hit      = (win_base_cnt >= THR_M1);

    case (state_q)
      IDLE, ALERT: begin
        win_cnt_d   = win_base_cnt;
        win_timer_d = win_base_tmr;
        if (bus.alarm_i) begin
          win_cnt_d = win_hit ? THR : win_base_cnt + C_ONE;
          state_d   = win_hit ? HALT : ALERT;
        end else if (sw_ok) begin
          state_d = IDLE;
        end else if (state_q == ALERT && bus.irq_ack_i) begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (bus.alarm_i)
          state_d = RESET_REQ;
        else if (halt_timer_q == HALT_LAST)
          state_d = ALERT;
        else
          halt_timer_d = halt_timer_q + HT_ONE;
      end
      RESET_REQ: begin
        rst_cnt_d = rst_cnt_q + C_ONE;
        state_d   = (rst_cnt_q == RST_LAST) ? LOCKOUT : IDLE;
      end
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    irq_d  = 1'b0;
    halt_d = 1'b0;
    rr_d   = 1'b0;
    lock_d = 1'b0;
    case (state_d)
      ALERT:     irq_d = 1'b1;
      HALT:      begin irq_d = 1'b1; halt_d = 1'b1; end
      RESET_REQ: begin irq_d = 1'b1; halt_d = 1'b1; rr_d = 1'b1; end
      LOCKOUT:   begin irq_d = 1'b1; halt_d = 1'b1; lock_d = 1'b1; end
      default:   ;
    endcase
  end

  assign bus.irq_o       = irq_q;
  assign bus.halt_o      = halt_q;
  assign bus.reset_req_o = rr_q;
  assign bus.lockout_o   = lock_q;
  assign bus.alarm_cnt_o = alarm_cnt_q;
  assign bus.state_o     = state_q;
endmodule
